// File: rtl/tea_block_engine.sv
`default_nettype none
// ============================================================================
// Module   : tea_block_engine
// Purpose  : TEA / XTEA 64-bit block cipher engine with configurable Feistel
//            cycle count, per-clock unrolling, valid/ready handshakes on both
//            sides, direct 128-bit key load and optional CBC chaining.
// Ports    : clk, reset (sync, active-high)
//            key_in[127:0], key_load      - key register load (IDLE only)
//            iv_in[63:0],   iv_load       - CBC chain load (IDLE only)
//            mode                         - 0 encrypt / 1 decrypt
//            in_valid, in_ready, data_in  - input block handshake
//            out_valid, out_ready,data_out- result handshake
// Options  : TEA_CBC_EN - when defined, adds the CBC chain register.
// Revision : 1.0 - initial release
// ============================================================================
module tea_block_engine #(
  parameter int          ALGO   = 0,
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] key_in,
  input  logic         key_load,
  input  logic [63:0]  iv_in,
  input  logic         iv_load,
  input  logic         mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out
);

  localparam logic [5:0]  c_rounds  = 6'(ROUNDS);
  localparam logic [5:0]  c_unroll  = 6'(UNROLL);
  // Decryption starts from the sum the encryption ends with.
  localparam logic [31:0] c_sum_dec = DELTA * 32'(ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [127:0] r_key;
  logic [31:0]  r_v0;
  logic [31:0]  r_v1;
  logic [31:0]  r_sum;
  logic [5:0]   r_cnt;
  logic         r_mode;
  logic [31:0]  w_v0;
  logic [31:0]  w_v1;
  logic [31:0]  w_sum;
  logic [63:0]  w_block_in;
  logic [63:0]  w_block_out;
  logic         w_start;
  logic         w_last;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_start   = (r_state == S_IDLE) && in_valid;
  // One extra RUN clock after the last cycle registers the result.
  assign w_last    = (r_state == S_RUN) && (r_cnt == c_rounds);

  function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = key[127:96];
      2'd1:    w = key[95:64];
      2'd2:    w = key[63:32];
      default: w = key[31:0];
    endcase
    return w;
  endfunction

  // UNROLL Feistel cycles chained combinationally from the current state.
  always_comb begin
    w_v0  = r_v0;
    w_v1  = r_v1;
    w_sum = r_sum;
    for (int i = 0; i < UNROLL; i++) begin
      if (ALGO == 0) begin
        if (!r_mode) begin
          w_sum = w_sum + DELTA;
          w_v0  = w_v0 + (((w_v1 << 4) + r_key[127:96]) ^ (w_v1 + w_sum) ^ ((w_v1 >> 5) + r_key[95:64]));
          w_v1  = w_v1 + (((w_v0 << 4) + r_key[63:32]) ^ (w_v0 + w_sum) ^ ((w_v0 >> 5) + r_key[31:0]));
        end else begin
          w_v1  = w_v1 - (((w_v0 << 4) + r_key[63:32]) ^ (w_v0 + w_sum) ^ ((w_v0 >> 5) + r_key[31:0]));
          w_v0  = w_v0 - (((w_v1 << 4) + r_key[127:96]) ^ (w_v1 + w_sum) ^ ((w_v1 >> 5) + r_key[95:64]));
          w_sum = w_sum - DELTA;
        end
      end else begin
        if (!r_mode) begin
          w_v0  = w_v0 + ((((w_v1 << 4) ^ (w_v1 >> 5)) + w_v1) ^ (w_sum + key_word(r_key, w_sum[1:0])));
          w_sum = w_sum + DELTA;
          w_v1  = w_v1 + ((((w_v0 << 4) ^ (w_v0 >> 5)) + w_v0) ^ (w_sum + key_word(r_key, w_sum[12:11])));
        end else begin
          w_v1  = w_v1 - ((((w_v0 << 4) ^ (w_v0 >> 5)) + w_v0) ^ (w_sum + key_word(r_key, w_sum[12:11])));
          w_sum = w_sum - DELTA;
          w_v0  = w_v0 - ((((w_v1 << 4) ^ (w_v1 >> 5)) + w_v1) ^ (w_sum + key_word(r_key, w_sum[1:0])));
        end
      end
    end
  end

`ifdef TEA_CBC_EN
  logic [63:0] r_chain;
  logic [63:0] r_din;
  logic [63:0] w_chain_cur;

  // An iv_load in the same clock as the handshake applies to that block.
  assign w_chain_cur = iv_load ? iv_in : r_chain;
  assign w_block_in  = mode ? data_in : (data_in ^ w_chain_cur);
  assign w_block_out = r_mode ? ({r_v0, r_v1} ^ r_chain) : {r_v0, r_v1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
      r_din   <= '0;
    end else begin
      if ((r_state == S_IDLE) && iv_load) r_chain <= iv_in;
      if (w_start) r_din <= data_in;
      if (w_last)  r_chain <= r_mode ? r_din : {r_v0, r_v1};
    end
  end
`else
  logic w_unused_iv;

  assign w_unused_iv = ^{iv_in, iv_load};
  assign w_block_in  = data_in;
  assign w_block_out = {r_v0, r_v1};
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key    <= '0;
      r_v0     <= '0;
      r_v1     <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_mode   <= 1'b0;
      data_out <= '0;
    end else begin
      // key_in captured alongside a handshake is used by that block, since
      // the first cycle is computed on the following clock.
      if ((r_state == S_IDLE) && key_load) r_key <= key_in;
      if (w_start) begin
        r_v0   <= w_block_in[63:32];
        r_v1   <= w_block_in[31:0];
        r_mode <= mode;
        r_sum  <= mode ? c_sum_dec : 32'd0;
        r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        if (w_last) begin
          data_out <= w_block_out;
        end else begin
          r_v0  <= w_v0;
          r_v1  <= w_v1;
          r_sum <= w_sum;
          r_cnt <= r_cnt + c_unroll;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tea_block_engine.sv
`timescale 1ns/1ps
`default_nettype none
module tb_tea_block_engine;

  localparam logic [31:0] DELTA    = 32'h9E3779B9;
  localparam int          ROUNDS   = 32;
  localparam int          UNROLL_T = 1;
  localparam int          UNROLL_X = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic [63:0]  iv_in = '0;
  logic         iv_load = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic [63:0]  data_in = '0;
  logic         out_ready = 1'b0;

  logic         t_in_ready, t_out_valid, x_in_ready, x_out_valid;
  logic [63:0]  t_data_out, x_data_out;

  always #5 clk = ~clk;

  tea_block_engine #(.ALGO(0), .ROUNDS(ROUNDS), .UNROLL(UNROLL_T), .DELTA(DELTA)) dut_tea (
    .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load),
    .iv_in(iv_in), .iv_load(iv_load), .mode(mode), .in_valid(in_valid),
    .in_ready(t_in_ready), .data_in(data_in), .out_valid(t_out_valid),
    .out_ready(out_ready), .data_out(t_data_out));

  tea_block_engine #(.ALGO(1), .ROUNDS(ROUNDS), .UNROLL(UNROLL_X), .DELTA(DELTA)) dut_xtea (
    .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load),
    .iv_in(iv_in), .iv_load(iv_load), .mode(mode), .in_valid(in_valid),
    .in_ready(x_in_ready), .data_in(data_in), .out_valid(x_out_valid),
    .out_ready(out_ready), .data_out(x_data_out));

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [63:0]  q_t[$];
  logic [63:0]  q_x[$];
  logic [127:0] m_key = '0;
  logic [63:0]  m_chain_t = '0;
  logic [63:0]  m_chain_x = '0;
  bit           hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Whole-block reference cipher, straight from the algorithm definition.
  function automatic logic [63:0] ref_cipher(input logic [63:0] v, input logic [127:0] k,
                                             input bit dec, input bit xtea);
    logic [31:0] v0, v1, sum;
    logic [31:0] kk[4];
    kk[0] = k[127:96]; kk[1] = k[95:64]; kk[2] = k[63:32]; kk[3] = k[31:0];
    v0 = v[63:32];
    v1 = v[31:0];
    sum = dec ? DELTA * 32'(ROUNDS) : 32'd0;
    for (int r = 0; r < ROUNDS; r++) begin
      if (!xtea && !dec) begin
        sum += DELTA;
        v0 += ((v1 << 4) + kk[0]) ^ (v1 + sum) ^ ((v1 >> 5) + kk[1]);
        v1 += ((v0 << 4) + kk[2]) ^ (v0 + sum) ^ ((v0 >> 5) + kk[3]);
      end else if (!xtea) begin
        v1 -= ((v0 << 4) + kk[2]) ^ (v0 + sum) ^ ((v0 >> 5) + kk[3]);
        v0 -= ((v1 << 4) + kk[0]) ^ (v1 + sum) ^ ((v1 >> 5) + kk[1]);
        sum -= DELTA;
      end else if (!dec) begin
        v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kk[sum[1:0]]);
        sum += DELTA;
        v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kk[sum[12:11]]);
      end else begin
        v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kk[sum[12:11]]);
        sum -= DELTA;
        v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kk[sum[1:0]]);
      end
    end
    return {v0, v1};
  endfunction

  task automatic wait_idle();
    int guard = 0;
    while (!(t_in_ready && x_in_ready) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 500) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle timeout: in_ready tea=%b xtea=%b required 1", t_in_ready, x_in_ready);
    end
  endtask

  // Issue one block to both engines; the expected results go on the
  // scoreboards (overridden by known plaintext/answer when ov_* is set).
  task automatic send(input logic [63:0] d, input bit m, input bit kl, input logic [127:0] k,
                      input bit ov_t, input logic [63:0] c_t, input bit ov_x, input logic [63:0] c_x,
                      output logic [63:0] e_t, output logic [63:0] e_x);
    logic [127:0] kuse;
    wait_idle();
    kuse = kl ? k : m_key;
    if (kl) m_key = k;
`ifdef TEA_CBC_EN
    if (!m) begin
      e_t = ref_cipher(d ^ m_chain_t, kuse, 1'b0, 1'b0); m_chain_t = e_t;
      e_x = ref_cipher(d ^ m_chain_x, kuse, 1'b0, 1'b1); m_chain_x = e_x;
    end else begin
      e_t = ref_cipher(d, kuse, 1'b1, 1'b0) ^ m_chain_t; m_chain_t = d;
      e_x = ref_cipher(d, kuse, 1'b1, 1'b1) ^ m_chain_x; m_chain_x = d;
    end
`else
    e_t = ref_cipher(d, kuse, m, 1'b0);
    e_x = ref_cipher(d, kuse, m, 1'b1);
`endif
    q_t.push_back(ov_t ? c_t : e_t);
    q_x.push_back(ov_x ? c_x : e_x);
    data_in = d; mode = m; key_load = kl; key_in = k; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; key_load = 1'b0;
  endtask

  task automatic load_iv(input logic [63:0] v);
    wait_idle();
    iv_in = v; iv_load = 1'b1;
`ifdef TEA_CBC_EN
    m_chain_t = v;
    m_chain_x = v;
`endif
    @(posedge clk); #1;
    iv_load = 1'b0;
  endtask

  // Monitor: latency of each result and scoreboard comparison on consumption.
  int t_start = 0, x_start = 0;
  bit t_prev = 1'b0, x_prev = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      t_prev = 1'b0;
      x_prev = 1'b0;
    end else begin
      if (in_valid && t_in_ready) t_start = cyc;
      if (in_valid && x_in_ready) x_start = cyc;
      if (t_out_valid && !t_prev) check_int("tea latency", cyc - t_start - 1, ROUNDS / UNROLL_T + 1);
      if (x_out_valid && !x_prev) check_int("xtea latency", cyc - x_start - 1, ROUNDS / UNROLL_X + 1);
      if (t_out_valid && out_ready) begin
        if (q_t.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tea unexpected output: got %h expected none", t_data_out);
        end else check64("tea data_out", t_data_out, q_t.pop_front());
      end
      if (x_out_valid && out_ready) begin
        if (q_x.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL xtea unexpected output: got %h expected none", x_data_out);
        end else check64("xtea data_out", x_data_out, q_x.pop_front());
      end
      t_prev = t_out_valid;
      x_prev = x_out_valid;
    end
  end

  // Consumer back-pressure.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [63:0]  d, et, ex, ct0, ct1, cx0, cx1, p0, p1;
    logic [127:0] k;
    int           guard;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check64("reset tea in_ready",   64'(t_in_ready),  64'd1);
    check64("reset tea out_valid",  64'(t_out_valid), 64'd0);
    check64("reset tea data_out",   t_data_out,       64'd0);
    check64("reset xtea in_ready",  64'(x_in_ready),  64'd1);
    check64("reset xtea out_valid", 64'(x_out_valid), 64'd0);
    check64("reset xtea data_out",  x_data_out,       64'd0);

    // Known-answer vectors with the all-zero key.
    send(64'h0, 1'b0, 1'b1, 128'h0, 1'b1, 64'h41EA3A0A94BAA940, 1'b1, 64'hDEE9D4D8F7131ED9, et, ex);
`ifndef TEA_CBC_EN
    send(64'h41EA3A0A94BAA940, 1'b1, 1'b0, 128'h0, 1'b1, 64'h0, 1'b0, 64'h0, et, ex);
    send(64'hDEE9D4D8F7131ED9, 1'b1, 1'b0, 128'h0, 1'b0, 64'h0, 1'b1, 64'h0, et, ex);
    // Ignored in ECB builds.
    load_iv({$urandom, $urandom});
    // Round trips: decrypting each engine's ciphertext recovers the plaintext.
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      send(d, 1'b0, 1'b1, k, 1'b0, 64'h0, 1'b0, 64'h0, et, ex);
      send(et, 1'b1, 1'b0, k, 1'b1, d, 1'b0, 64'h0, ct0, cx0);
      send(ex, 1'b1, 1'b0, k, 1'b0, 64'h0, 1'b1, d, ct0, cx0);
    end
`else
    p0 = {$urandom, $urandom};
    p1 = {$urandom, $urandom};
    k  = {$urandom, $urandom, $urandom, $urandom};
    load_iv(64'h0123456789ABCDEF);
    send(p0, 1'b0, 1'b1, k, 1'b0, 64'h0, 1'b0, 64'h0, ct0, cx0);
    send(p1, 1'b0, 1'b0, k, 1'b0, 64'h0, 1'b0, 64'h0, ct1, cx1);
    load_iv(64'h0123456789ABCDEF);
    send(ct0, 1'b1, 1'b0, k, 1'b1, p0, 1'b0, 64'h0, et, ex);
    send(ct1, 1'b1, 1'b0, k, 1'b1, p1, 1'b0, 64'h0, et, ex);
    load_iv(64'h0123456789ABCDEF);
    send(cx0, 1'b1, 1'b0, k, 1'b0, 64'h0, 1'b1, p0, et, ex);
    send(cx1, 1'b1, 1'b0, k, 1'b0, 64'h0, 1'b1, p1, et, ex);
`endif

    // Randomised traffic with occasional key reloads and idle gaps.
    for (int i = 0; i < 20; i++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), k,
           1'b0, 64'h0, 1'b0, 64'h0, et, ex);
    end

    // Hold the result in DONE: stable output, no acceptance, key_load ignored.
    wait_idle();
    hold = 1'b1;
    @(posedge clk); #1;
    send({$urandom, $urandom}, 1'b0, 1'b0, 128'h0, 1'b0, 64'h0, 1'b0, 64'h0, et, ex);
    guard = 0;
    while (!t_out_valid && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      check64("hold tea data_out",   t_data_out,          et);
      check64("hold xtea data_out",  x_data_out,          ex);
      check64("hold tea in_ready",   64'(t_in_ready),     64'd0);
      check64("hold tea out_valid",  64'(t_out_valid),    64'd1);
      check64("hold xtea in_ready",  64'(x_in_ready),     64'd0);
      in_valid = 1'b1; key_load = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      data_in = {$urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; key_load = 1'b0;
    hold = 1'b0;
    send({$urandom, $urandom}, 1'b0, 1'b0, 128'h0, 1'b0, 64'h0, 1'b0, 64'h0, et, ex);

    // Reset in the middle of a block aborts it.
    wait_idle();
    hold = 1'b1;
    @(posedge clk); #1;
    send({$urandom, $urandom}, 1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom},
         1'b0, 64'h0, 1'b0, 64'h0, et, ex);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q_t.delete();
    q_x.delete();
    m_key = '0;
    m_chain_t = '0;
    m_chain_x = '0;
    check64("abort tea out_valid",  64'(t_out_valid), 64'd0);
    check64("abort tea in_ready",   64'(t_in_ready),  64'd1);
    check64("abort tea data_out",   t_data_out,       64'd0);
    check64("abort xtea out_valid", 64'(x_out_valid), 64'd0);
    check64("abort xtea in_ready",  64'(x_in_ready),  64'd1);
    hold = 1'b0;
    send({$urandom, $urandom}, 1'b0, 1'b0, 128'h0, 1'b0, 64'h0, 1'b0, 64'h0, et, ex);
    send({$urandom, $urandom}, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom},
         1'b0, 64'h0, 1'b0, 64'h0, et, ex);

    guard = 0;
    while ((q_t.size() != 0 || q_x.size() != 0) && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check_int("tea results outstanding",  q_t.size(), 0);
    check_int("xtea results outstanding", q_x.size(), 0);
    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
